// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, PC mux select codes
// and the default reset PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the architectural PC, handshakes with instruction
// memory, holds each instruction for execute and steers the external PC mux.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Valid,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] INSTR,
  output logic        INSTR_Valid,
  input  logic        INSTR_Ready,
  output logic [31:0] PC,
  input  logic        Branch,
  input  logic        Br_Taken,
  input  logic        Jal,
  input  logic        Jalr,
  output logic [1:0]  PC_Sel,
  input  logic [31:0] PC_Next,
  output logic        Misalign_Err,
  output logic [31:0] Retired
);

  state_t      state;
  logic [31:0] pc_reg;

  assign PC        = pc_reg;
  assign IMEM_Addr = pc_reg;

  // Jalr has top priority so conflicting decode flags resolve deterministically.
  always_comb begin
    PC_Sel = PC_SEL_SEQ;
    if (state == S_ISSUE) begin
      if (Jalr)
        PC_Sel = PC_SEL_JALR;
      else if (Jal || (Branch && Br_Taken))
        PC_Sel = PC_SEL_IMM;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= S_IDLE;
      pc_reg       <= RESET_PC;
      IMEM_Req     <= 1'b0;
      INSTR        <= 32'h0;
      INSTR_Valid  <= 1'b0;
      Misalign_Err <= 1'b0;
      Retired      <= 32'h0;
    end else begin
      IMEM_Req <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          IMEM_Req <= 1'b1;
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_Valid) begin
            INSTR       <= IMEM_Data;
            INSTR_Valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A misaligned next PC freezes the core until reset; PC stays on the
          // offending instruction for debug.
          if (INSTR_Ready) begin
            INSTR_Valid <= 1'b0;
            if (PC_Next[1:0] == 2'b00) begin
              pc_reg   <= PC_Next;
              Retired  <= Retired + 32'd1;
              IMEM_Req <= 1'b1;
              state    <= S_REQ;
            end else begin
              Misalign_Err <= 1'b1;
              state        <= S_HALT;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed and randomized fetches against
// a transaction-level model of PC, retire count and error flag.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Valid = 1'b0;
  logic [31:0] IMEM_Data = 32'h0;
  logic [31:0] INSTR;
  logic        INSTR_Valid;
  logic        INSTR_Ready = 1'b0;
  logic [31:0] PC;
  logic        Branch = 1'b0;
  logic        Br_Taken = 1'b0;
  logic        Jal = 1'b0;
  logic        Jalr = 1'b0;
  logic [1:0]  PC_Sel;
  logic [31:0] PC_Next = 32'h0;
  logic        Misalign_Err;
  logic [31:0] Retired;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr),
    .IMEM_Valid(IMEM_Valid), .IMEM_Data(IMEM_Data),
    .INSTR(INSTR), .INSTR_Valid(INSTR_Valid), .INSTR_Ready(INSTR_Ready),
    .PC(PC),
    .Branch(Branch), .Br_Taken(Br_Taken), .Jal(Jal), .Jalr(Jalr),
    .PC_Sel(PC_Sel), .PC_Next(PC_Next),
    .Misalign_Err(Misalign_Err), .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_flags();
    Branch   = 1'($urandom_range(0, 1));
    Br_Taken = 1'($urandom_range(0, 1));
    Jal      = 1'($urandom_range(0, 1));
    Jalr     = 1'($urandom_range(0, 1));
  endtask

  // Reference: what kind of control transfer the decode flags describe.
  function automatic logic [1:0] ref_sel(input logic br, input logic tk,
                                         input logic jal, input logic jalr);
    if (jalr) return 2'b10;
    if (jal || (br && tk)) return 2'b01;
    return 2'b00;
  endfunction

  // Reference PC mux: sequential, PC-relative, or register-indirect with LSB cleared.
  function automatic logic [31:0] ref_next(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] imm, input logic [31:0] base);
    case (sel)
      2'b00:   return pc + 32'd4;
      2'b01:   return pc + imm;
      default: return (base + imm) & ~32'd1;
    endcase
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},    IMEM_Req,     0);
    chk({tag, "_addr"},   IMEM_Addr,    RST_PC);
    chk({tag, "_pc"},     PC,           RST_PC);
    chk({tag, "_instr"},  INSTR,        0);
    chk({tag, "_ivalid"}, INSTR_Valid,  0);
    chk({tag, "_sel"},    PC_Sel,       0);
    chk({tag, "_err"},    Misalign_Err, 0);
    chk({tag, "_ret"},    Retired,      0);
  endtask

  // One complete fetch, entered one cycle into the request pulse.
  task automatic fetch(input int lat, input int stall,
                       input logic br, input logic tk, input logic jal, input logic jalr,
                       input logic [31:0] imm, input logic [31:0] base,
                       input logic [31:0] word);
    logic [1:0]  sel;
    logic [31:0] nxt;
    chk("req_pulse", IMEM_Req, 1);
    chk("req_addr", IMEM_Addr, exp_pc);
    rand_flags();
    IMEM_Valid = 1'b1;
    IMEM_Data  = ~word;
    #1;
    chk("sel_req", PC_Sel, 0);
    tick();
    for (int i = 1; i <= lat; i++) begin
      chk("wait_req", IMEM_Req, 0);
      chk("wait_ivalid", INSTR_Valid, 0);
      rand_flags();
      IMEM_Valid = (i == lat);
      IMEM_Data  = (i == lat) ? word : $urandom;
      #1;
      chk("sel_wait", PC_Sel, 0);
      tick();
    end
    IMEM_Valid = 1'b0;
    chk("issue_ivalid", INSTR_Valid, 1);
    chk("issue_instr", INSTR, word);
    chk("issue_pc", PC, exp_pc);
    chk("issue_ret", Retired, exp_retired);
    Branch = br; Br_Taken = tk; Jal = jal; Jalr = jalr;
    sel = ref_sel(br, tk, jal, jalr);
    nxt = ref_next(sel, exp_pc, imm, base);
    PC_Next = 32'h0000_0002;
    #1;
    chk("issue_sel", PC_Sel, sel);
    for (int i = 0; i < stall; i++) begin
      INSTR_Ready = 1'b0;
      IMEM_Valid  = 1'b1;
      IMEM_Data   = $urandom;
      tick();
      chk("stall_instr", INSTR, word);
      chk("stall_pc", PC, exp_pc);
      chk("stall_ivalid", INSTR_Valid, 1);
    end
    IMEM_Valid  = 1'b0;
    INSTR_Ready = 1'b1;
    PC_Next     = nxt;
    tick();
    INSTR_Ready = 1'b0;
    Branch = 1'b0; Br_Taken = 1'b0; Jal = 1'b0; Jalr = 1'b0;
    if (nxt[1:0] == 2'b00) begin
      exp_pc      = nxt;
      exp_retired = exp_retired + 1;
      chk("hs_ret", Retired, exp_retired);
      chk("hs_pc", PC, exp_pc);
      chk("hs_err", Misalign_Err, 0);
    end else begin
      chk("mis_err", Misalign_Err, 1);
      chk("mis_ivalid", INSTR_Valid, 0);
      chk("mis_pc", PC, exp_pc);
      chk("mis_ret", Retired, exp_retired);
    end
  endtask

  initial begin
    exp_pc      = RST_PC;
    exp_retired = 0;

    // Reset held: every output at its reset value.
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_state("rst");

    // Release: cycle 0 idle, request pulses in cycle 1.
    RSTN = 1'b1;
    chk("c0_req", IMEM_Req, 0);
    tick();

    // Sequential fetches with 1-cycle memory and no stalls.
    for (int i = 0; i < 3; i++)
      fetch(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
    chk("seq_addr", IMEM_Addr, 32'h0000_010C);
    chk("seq_ret", Retired, 3);

    // Taken branch to 0x180.
    fetch(1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0180 - exp_pc, 32'h0, $urandom);
    chk("br_addr", IMEM_Addr, 32'h0000_0180);

    // Jal and Jalr together: Jalr target 0x200 wins.
    fetch(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0201, $urandom);
    chk("jalr_addr", IMEM_Addr, 32'h0000_0200);

    // Randomized traffic with aligned targets.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] imm;
      logic [31:0] base;
      imm  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      base = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
      fetch(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            imm, base, $urandom);
    end

    // Reset while a request is outstanding, followed by a stale response.
    tick();
    RSTN = 1'b0;
    #1;
    chk_reset_state("rst_wait");
    exp_pc      = RST_PC;
    exp_retired = 0;
    tick();
    IMEM_Valid = 1'b1;
    IMEM_Data  = 32'hDEAD_BEEF;
    RSTN       = 1'b1;
    tick();
    IMEM_Valid = 1'b0;
    chk("stale_instr", INSTR, 0);
    chk("stale_ivalid", INSTR_Valid, 0);
    fetch(2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
    fetch(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);

    // Five-cycle stall, then a misaligned PC_Next of 0x10A halts the core.
    fetch(1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_010A, 32'hCAFE_0001);
    for (int i = 0; i < 8; i++) begin
      IMEM_Valid = 1'($urandom_range(0, 1));
      IMEM_Data  = $urandom;
      INSTR_Ready = 1'($urandom_range(0, 1));
      tick();
      chk("halt_req", IMEM_Req, 0);
      chk("halt_ivalid", INSTR_Valid, 0);
      chk("halt_err", Misalign_Err, 1);
    end
    chk("halt_pc", PC, exp_pc);
    chk("halt_ret", Retired, exp_retired);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
